// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Purpose  : Shared word width and fetch entry type used by fetch, queue and
//            decode.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular FIFO that decouples the fetch stage from decode, with
//            stall (freeze) and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_instruction,
    output logic              in_ready,
    input  logic              flush,
    input  logic              freeze,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_instruction,
    input  logic              out_ready,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0]   c_FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_head;

    assign in_ready  = (r_count != c_FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~freeze & ~flush;

    // Head is masked to zero when empty so stale storage never leaks out.
    assign w_head          = r_mem[r_rd_ptr];
    assign out_pc          = out_valid ? w_head.pc          : '0;
    assign out_instruction = out_valid ? w_head.instruction : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: in_pc, instruction: in_instruction};
        end
    end

    // Occupancy is tracked separately from the pointers so full and empty
    // never alias when the pointers are equal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        flush;
    logic        freeze;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_err    = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_instruction (in_instruction),
        .in_ready       (in_ready),
        .flush          (flush),
        .freeze         (freeze),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction),
        .out_ready      (out_ready),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iin;
        logic        fl;
        logic        fz;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_in;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] ipc, input logic [31:0] iin,
                                input logic fl, input logic fz, input logic ordy,
                                input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_in,
                                input logic [2:0] e_cnt, input logic e_ir);
        vec_t v;
        v.iv = iv; v.ipc = ipc; v.iin = iin; v.fl = fl; v.fz = fz; v.ordy = ordy;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_in = e_in; v.e_cnt = e_cnt; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ov, input logic [31:0] e_pc,
                           input logic [31:0] e_in, input logic [2:0] e_cnt, input logic e_ir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_pc"}, out_pc, e_pc);
        chk({tag, ".out_instruction"}, out_instruction, e_in);
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_ir));
    endtask

    task automatic drive(input logic iv, input logic [31:0] ipc, input logic [31:0] iin,
                         input logic fl, input logic fz, input logic ordy);
        in_valid = iv; in_pc = ipc; in_instruction = iin;
        flush = fl; freeze = fz; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] head;
        logic        r_iv, r_fl, r_fz, r_or, do_push, do_pop;
        logic [31:0] r_pc, r_in;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("reset", 0, 0, 0, 0, 1);
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        // Fill to full, rejected fifth push, drain
        vecs.push_back(mk(1, 32'h0,  32'hE3A00001, 0, 0, 0,  1, 32'h0, 32'hE3A00001, 1, 1));
        vecs.push_back(mk(1, 32'h4,  32'hE3A00002, 0, 0, 0,  1, 32'h0, 32'hE3A00001, 2, 1));
        vecs.push_back(mk(1, 32'h8,  32'hE3A00003, 0, 0, 0,  1, 32'h0, 32'hE3A00001, 3, 1));
        vecs.push_back(mk(1, 32'hC,  32'hE3A00004, 0, 0, 0,  1, 32'h0, 32'hE3A00001, 4, 0));
        vecs.push_back(mk(1, 32'h10, 32'hE3A00005, 0, 0, 0,  1, 32'h0, 32'hE3A00001, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h4, 32'hE3A00002, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h8, 32'hE3A00003, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'hC, 32'hE3A00004, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // Freeze holds the head stable
        vecs.push_back(mk(1, 32'h20, 32'hE5901020, 0, 0, 0,  1, 32'h20, 32'hE5901020, 1, 1));
        vecs.push_back(mk(1, 32'h24, 32'hE5901024, 0, 0, 0,  1, 32'h20, 32'hE5901020, 2, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1,  1, 32'h20, 32'hE5901020, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h24, 32'hE5901024, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // Flush with concurrent push and pop, then a fresh push
        vecs.push_back(mk(1, 32'h30, 32'hA0000030, 0, 0, 0,  1, 32'h30, 32'hA0000030, 1, 1));
        vecs.push_back(mk(1, 32'h34, 32'hA0000034, 0, 0, 0,  1, 32'h30, 32'hA0000030, 2, 1));
        vecs.push_back(mk(1, 32'h38, 32'hA0000038, 0, 0, 0,  1, 32'h30, 32'hA0000030, 3, 1));
        vecs.push_back(mk(1, 32'h100, 32'hA0000100, 1, 0, 1,  0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h200, 32'hA0000200, 0, 0, 0,  1, 32'h200, 32'hA0000200, 1, 1));
        // Flush overrides freeze
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 1));
        // Full with a pop: the pop happens, the push is ignored
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h40 + 32'(4*i), 32'hB0 + 32'(i), 0, 0, 0,
                              1, 32'h40, 32'hB0, 3'(i+1), (i != 3)));
        vecs.push_back(mk(1, 32'h99, 32'h99, 0, 0, 1,  1, 32'h44, 32'hB1, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ipc, vecs[i].iin, vecs[i].fl, vecs[i].fz, vecs[i].ordy);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_in,
                    vecs[i].e_cnt, vecs[i].e_ir);
        end

        // Wrap-around: continuous push/pop, head always the just-pushed entry
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'(4*k), 32'hC0DE0000 + 32'(k), 0, 0, 1);
            tick();
            chk_all($sformatf("wrap%0d", k), 1, 32'(4*k), 32'hC0DE0000 + 32'(k), 1, 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk_all("wrap_end", 0, 0, 0, 0, 1);

        // Asynchronous reset between clock edges
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h500 + 32'(4*k), 32'hD0 + 32'(k), 0, 0, 0);
            tick();
        end
        chk_all("pre_arst", 1, 32'h500, 32'hD0, 3, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_all("arst", 0, 0, 0, 0, 1);
        #2 rst = 1'b0;
        tick();
        chk_all("post_arst", 0, 0, 0, 0, 1);

        // Randomized traffic against a queue reference model
        q.delete();
        for (int c = 0; c < 400; c++) begin
            r_iv = ($urandom_range(0, 3) != 0);
            r_pc = $urandom;
            r_in = $urandom;
            r_fl = ($urandom_range(0, 15) == 0);
            r_fz = ($urandom_range(0, 3) == 0);
            r_or = ($urandom_range(0, 2) != 0);
            drive(r_iv, r_pc, r_in, r_fl, r_fz, r_or);
            if (r_fl) begin
                q.delete();
            end else begin
                do_push = r_iv && (q.size() < DEPTH);
                do_pop  = r_or && !r_fz && (q.size() > 0);
                if (do_pop)  void'(q.pop_front());
                if (do_push) q.push_back({r_pc, r_in});
            end
            tick();
            head = (q.size() > 0) ? q[0] : 64'd0;
            chk_all($sformatf("rnd%0d", c), (q.size() > 0), head[63:32], head[31:0],
                    3'(q.size()), (q.size() != DEPTH));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
